// File: rtl/genram_burst_writer.sv
// rtl/genram_burst_writer.sv - bounds-checked byte-serial RAM burst writer; optional byte mask via GENRAM_BYTE_MASK_EN
module genram_burst_writer #(
  parameter int AW    = 6,
  parameter int DW    = 8,
  parameter int EXTRA = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AW:0]               addr,
  input  logic [EXTRA-1:0]          extra,
  input  logic [(2**EXTRA)*8-1:0]   data,
`ifdef GENRAM_BYTE_MASK_EN
  input  logic [2**EXTRA-1:0]       byte_mask,
`endif
  input  logic [AW:0]               lower_bound,
  input  logic [AW:0]               upper_bound,
  input  logic                      valid,
  output logic                      ready,
  output logic                      done,
  output logic                      error,
  output logic                      ram_we,
  output logic [AW:0]               ram_addr,
  output logic [DW-1:0]             ram_wdata
);

  localparam int NB  = 2**EXTRA;
  localparam int DBW = NB * 8;

  generate
    if (DW != 8) begin : g_dw_check
      $error("genram_burst_writer: DW must be 8");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE, S_ERR} state_t;

  state_t           r_state;
  state_t           w_next_state;

  // Remaining bytes/mask are kept pre-shifted so byte i always sits in the low lane.
  logic [EXTRA-1:0] r_cnt,       w_cnt;
  logic [DBW-1:0]   r_data,      w_data;
  logic [NB-1:0]    r_mask,      w_mask;
  logic             r_ram_we,    w_ram_we;
  logic [AW:0]      r_ram_addr,  w_ram_addr;
  logic [DW-1:0]    r_ram_wdata, w_ram_wdata;
  logic             r_done,      w_done;
  logic             r_error,     w_error;

  logic [NB-1:0]    w_mask_in;
  logic [AW+1:0]    w_end;
  logic             w_reject;

`ifdef GENRAM_BYTE_MASK_EN
  assign w_mask_in = byte_mask;
`else
  assign w_mask_in = '1;
`endif

  // One extra bit on the end address so addr+extra cannot wrap past the top of memory.
  assign w_end    = {1'b0, addr} + (AW+2)'(extra);
  // An inverted window (lower > upper) fails one of these two tests for any addr.
  assign w_reject = (addr < lower_bound) | (w_end > {1'b0, upper_bound});

  assign ready     = (r_state == S_IDLE);
  assign done      = r_done;
  assign error     = r_error;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state and next values of every registered output and burst register.
  always_comb begin
    w_next_state = r_state;
    w_cnt        = r_cnt;
    w_data       = r_data;
    w_mask       = r_mask;
    w_ram_we     = 1'b0;
    w_ram_addr   = r_ram_addr;
    w_ram_wdata  = r_ram_wdata;
    w_done       = 1'b0;
    w_error      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid) begin
          if (w_reject) begin
            w_next_state = S_ERR;
            w_done       = 1'b1;
            w_error      = 1'b1;
          end else begin
            // Byte 0 goes out in the cycle right after accept.
            w_next_state = S_WRITE;
            w_cnt        = extra;
            w_ram_we     = w_mask_in[0];
            w_ram_addr   = addr;
            w_ram_wdata  = data[DW-1:0];
            w_data       = data >> 8;
            w_mask       = w_mask_in >> 1;
          end
        end
      end
      S_WRITE: begin
        if (r_cnt == '0) begin
          w_next_state = S_DONE;
          w_done       = 1'b1;
        end else begin
          w_cnt       = r_cnt - EXTRA'(1);
          w_ram_we    = r_mask[0];
          w_ram_addr  = r_ram_addr + (AW+1)'(1);
          w_ram_wdata = r_data[DW-1:0];
          w_data      = r_data >> 8;
          w_mask      = r_mask >> 1;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      S_ERR:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Burst registers and registered RAM/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_data      <= '0;
      r_mask      <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_cnt       <= w_cnt;
      r_data      <= w_data;
      r_mask      <= w_mask;
      r_ram_we    <= w_ram_we;
      r_ram_addr  <= w_ram_addr;
      r_ram_wdata <= w_ram_wdata;
      r_done      <= w_done;
      r_error     <= w_error;
    end
  end

endmodule

// File: tb/tb_genram_burst_writer.sv
// tb/tb_genram_burst_writer.sv - randomized model-checked bench for genram_burst_writer
`timescale 1ns/1ps
module tb_genram_burst_writer;
  localparam int AW    = 6;
  localparam int EXTRA = 4;
  localparam int NB    = 16;
  localparam int DBW   = 128;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [AW:0]      addr = '0;
  logic [EXTRA-1:0] extra = '0;
  logic [DBW-1:0]   data = '0;
  logic [NB-1:0]    mask = '1;
  logic [AW:0]      lo = '0;
  logic [AW:0]      hi = 7'd127;
  logic             valid = 1'b0;
  logic             ready, done, error, ram_we;
  logic [AW:0]      ram_addr;
  logic [7:0]       ram_wdata;

  always #5 clk = ~clk;

  genram_burst_writer #(.AW(AW), .DW(8), .EXTRA(EXTRA)) dut (
    .clk(clk),
    .reset(rst),
    .addr(addr),
    .extra(extra),
    .data(data),
`ifdef GENRAM_BYTE_MASK_EN
    .byte_mask(mask),
`endif
    .lower_bound(lo),
    .upper_bound(hi),
    .valid(valid),
    .ready(ready),
    .done(done),
    .error(error),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata)
  );

  // Expected outputs for one clock cycle.
  typedef struct {
    bit wr;
    bit we;
    int a;
    int d;
    bit done;
    bit err;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  bit   busy   = 0;
  int   n_acc  = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic rec_t idle_rec();
    rec_t r;
    r.wr = 0; r.we = 0; r.a = 0; r.d = 0; r.done = 0; r.err = 0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // A request becomes either one error cycle, or n write cycles followed by one done cycle.
  task automatic model_accept();
    rec_t r;
    int a;
    int e;
    a = int'(addr);
    e = int'(extra);
    if (a < int'(lo) || a + e > int'(hi)) begin
      r = idle_rec(); r.done = 1; r.err = 1;
      q.push_back(r);
    end else begin
      for (int i = 0; i <= e; i++) begin
        r = idle_rec();
        r.wr = 1;
`ifdef GENRAM_BYTE_MASK_EN
        r.we = mask[i];
`else
        r.we = 1;
`endif
        r.a = a + i;
        r.d = int'(data[8*i +: 8]);
        q.push_back(r);
      end
      r = idle_rec(); r.done = 1;
      q.push_back(r);
    end
  endtask

  // One clock: model accept at the rising edge, compare at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) q.delete();
    else if (valid && !busy) begin
      model_accept();
      n_acc++;
    end
    @(negedge clk);
    if (rst) q.delete();
    if (q.size() > 0) begin
      cur  = q.pop_front();
      busy = 1;
    end else begin
      cur  = idle_rec();
      busy = 0;
    end
    chk("ready", ready, !busy);
    chk("done", done, cur.done);
    chk("error", error, cur.err);
    chk("ram_we", ram_we, cur.we);
    if (cur.wr) begin
      chk("ram_addr", ram_addr, cur.a);
      chk("ram_wdata", ram_wdata, cur.d);
    end
    if (rst) chk("ram_addr_in_reset", ram_addr, 0);
  endtask

  // Present a request and clock until it is accepted; returns in cycle k+1.
  task automatic send(input int a, input int e, input logic [DBW-1:0] d,
                      input logic [NB-1:0] m, input bit hold);
    int start;
    int t;
    start = n_acc;
    t = 0;
    addr = 7'(a); extra = 4'(e); data = d; mask = m; valid = 1'b1;
    while (n_acc == start && t < 64) begin
      step();
      t++;
    end
    if (n_acc == start) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept within 64 cycles");
    end
    if (!hold) valid = 1'b0;
  endtask

  initial begin : main
    int c;
    int start;
    int a;
    int e;
    bit hold;
    logic [DBW-1:0] d;
    cur = idle_rec();

    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("t1_ready", ready, 1);
    chk("t1_done", done, 0);
    chk("t1_error", error, 0);
    chk("t1_we", ram_we, 0);
    chk("t1_addr", ram_addr, 0);

    send(10, 3, 128'h44332211, '1, 0);
    chk("t2_we0", ram_we, 1); chk("t2_a0", ram_addr, 10); chk("t2_d0", ram_wdata, 8'h11);
    step(); chk("t2_a1", ram_addr, 11); chk("t2_d1", ram_wdata, 8'h22);
    step(); chk("t2_a2", ram_addr, 12); chk("t2_d2", ram_wdata, 8'h33);
    step(); chk("t2_a3", ram_addr, 13); chk("t2_d3", ram_wdata, 8'h44);
    step(); chk("t2_done", done, 1); chk("t2_error", error, 0); chk("t2_we_off", ram_we, 0);

    lo = 7'd8; hi = 7'd15;
    send(14, 3, 128'h1, '1, 0);
    chk("t3_done", done, 1); chk("t3_error", error, 1); chk("t3_we", ram_we, 0);
    step(); chk("t3_ready", ready, 1);
    lo = 7'd0; hi = 7'd127;

    send(126, 3, 128'h55, '1, 0);
    chk("t4_wrap_error", error, 1);
    send(124, 3, 128'h99887766, '1, 0);
    chk("t4_ok_we", ram_we, 1); chk("t4_ok_addr", ram_addr, 124); chk("t4_ok_error", error, 0);

    send(20, 3, 128'hDDCCBBAA, '1, 0);
    step(); chk("t5_d1", ram_wdata, 8'hBB);
    #1 rst = 1'b1;
    #1 chk("t5_we_async", ram_we, 0); chk("t5_ready_async", ready, 1);
    step();
    rst = 1'b0;
    step(); chk("t5_ready", ready, 1); chk("t5_addr", ram_addr, 0);
    step();

    send(30, 3, 128'h04030201, '1, 1);
    addr = 7'd40; extra = 4'd1; data = 128'hBEEF;
    start = n_acc;
    c = 0;
    while (n_acc == start && c < 64) begin
      step();
      c++;
    end
    valid = 1'b0;
    chk("t6_gap", c, 6);
    chk("t6_b_addr", ram_addr, 40); chk("t6_b_data", ram_wdata, 8'hEF);

`ifdef GENRAM_BYTE_MASK_EN
    send(50, 3, 128'hA4A3A2A1, 16'h0005, 0);
    chk("t6_m0", ram_we, 1);
    step(); chk("t6_m1", ram_we, 0); chk("t6_m1_addr", ram_addr, 51);
    step(); chk("t6_m2", ram_we, 1);
    step(); chk("t6_m3", ram_we, 0);
`endif

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        lo = 7'($urandom_range(0, 127));
        hi = 7'($urandom_range(0, 127));
      end else begin
        lo = 7'd0;
        hi = 7'd127;
      end
      d = {$urandom, $urandom, $urandom, $urandom};
      e = int'($urandom_range(0, 15));
      a = int'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) begin
        a = 127 - e + int'($urandom_range(0, 3));
        if (a > 127) a = 127;
      end
      hold = 1'($urandom_range(0, 1));
      send(a, e, d, 16'($urandom), hold);
      repeat ($urandom_range(0, 2)) step();
    end
    valid = 1'b0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
